lsp_prev_compose_ctrl: RTL and testbench

Sequencer for the G.729 Lsp_prev_compose computation. For j = 0..M-1 it computes lsp[j] = extract_h(L_mult(lsp_ele[j], fg_sum[j]) + sum over k of L_mac(freq_prev[k][j], fg[k][j])).
- Drives the shared scratch memory read/write ports, the constant memory address, and the external L_mult and L_mac operators.
- Sits between the Qua_Lsp top FSM (start/done) and the compose datapath.

---
 rtl/lsp_pkg.sv | 25 ++
 rtl/lsp_prev_compose_agen.sv | 81 ++++++++
 rtl/lsp_prev_compose_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_lsp_prev_compose_ctrl.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsp_pkg.sv
// Shared definitions for the Lsp_prev_compose sequencer: default geometry,
// controller state encoding and a small sign-extension helper.
package lsp_pkg;

  localparam int unsigned LSP_M       = 10;  // LSP order
  localparam int unsigned LSP_MA_NP   = 4;   // MA predictor order
  localparam int unsigned LSP_ADDR_W  = 11;  // scratch memory address width
  localparam int unsigned LSP_CADDR_W = 12;  // constant memory address width

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_INIT = 3'd1,
    ST_MULT    = 3'd2,
    ST_RD_MAC  = 3'd3,
    ST_MAC     = 3'd4,
    ST_WRITE   = 3'd5,
    ST_DONE    = 3'd6
  } lsp_state_t;

  // extract_h result widened back to a 32-bit memory word
  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/lsp_prev_compose_agen.sv
// Address generator for Lsp_prev_compose: element counter j, MAC counter k
// and a running row offset k*M, so no multiplier is needed. Read addresses
// are produced from the next counter values so the controller can register
// them on the edge that enters the corresponding read state.
module lsp_prev_compose_agen
  import lsp_pkg::*;
#(
  parameter int unsigned M       = LSP_M,
  parameter int unsigned MA_NP   = LSP_MA_NP,
  parameter int unsigned ADDR_W  = LSP_ADDR_W,
  parameter int unsigned CADDR_W = LSP_CADDR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr_j,
  input  logic               inc_j,
  input  logic               clr_k,
  input  logic               inc_k,
  input  logic [ADDR_W-1:0]  lsp_ele_base,
  input  logic [ADDR_W-1:0]  freq_prev_base,
  input  logic [ADDR_W-1:0]  lsp_base,
  input  logic [CADDR_W-1:0] fg_sum_base,
  input  logic [CADDR_W-1:0] fg_base,
  output logic               last_j,
  output logic               last_k,
  output logic [ADDR_W-1:0]  ele_addr,
  output logic [ADDR_W-1:0]  fp_addr,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [CADDR_W-1:0] fg_sum_addr,
  output logic [CADDR_W-1:0] fg_addr
);

  localparam int unsigned J_W   = (M > 1) ? $clog2(M) : 1;
  localparam int unsigned K_W   = (MA_NP > 1) ? $clog2(MA_NP) : 1;
  localparam int unsigned ROW_W = ((M * MA_NP) > 1) ? $clog2(M * MA_NP) : 1;

  logic [J_W-1:0]   j_q, j_d;
  logic [K_W-1:0]   k_q, k_d;
  logic [ROW_W-1:0] row_q, row_d;

  // Next counter values from the controller's clear/increment requests
  always_comb begin
    j_d   = j_q;
    k_d   = k_q;
    row_d = row_q;
    if (clr_j) begin
      j_d = '0;
    end else if (inc_j) begin
      j_d = j_q + J_W'(1);
    end
    if (clr_k) begin
      k_d   = '0;
      row_d = '0;
    end else if (inc_k) begin
      k_d   = k_q + K_W'(1);
      row_d = row_q + ROW_W'(M);
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      j_q   <= '0;
      k_q   <= '0;
      row_q <= '0;
    end else begin
      j_q   <= j_d;
      k_q   <= k_d;
      row_q <= row_d;
    end
  end

  assign last_j      = (j_q == J_W'(M - 1));
  assign last_k      = (k_q == K_W'(MA_NP - 1));
  assign ele_addr    = lsp_ele_base + ADDR_W'(j_d);
  assign fp_addr     = freq_prev_base + ADDR_W'(row_d) + ADDR_W'(j_d);
  assign fg_sum_addr = fg_sum_base + CADDR_W'(j_d);
  assign fg_addr     = fg_base + CADDR_W'(row_d) + CADDR_W'(j_d);
  assign wr_addr     = lsp_base + ADDR_W'(j_q);

endmodule

// File: rtl/lsp_prev_compose_ctrl.sv
// Lsp_prev_compose sequencer: for each j computes
//   lsp[j] = extract_h(L_mult(lsp_ele[j], fg_sum[j]) + sum_k L_mac(freq_prev[k][j], fg[k][j]))
// driving the scratch/constant memories and the external L_mult/L_mac units.
// Optional feature macro: LSP_PREV_COMPOSE_OVF_EN (sticky overflow flag).
//
// All outputs are registered. Because memory data arrives in MULT/MAC and the
// operand outputs are registered, the operator results are consumed one cycle
// later (the following RD_MAC or WRITE cycle), tracked by mult_pend/mac_pend.
// Per-element length stays 1 + 1 + 2*MA_NP + 1 cycles; the final write strobe
// and the done pulse share the DONE cycle.
module lsp_prev_compose_ctrl
  import lsp_pkg::*;
#(
  parameter int unsigned M       = LSP_M,
  parameter int unsigned MA_NP   = LSP_MA_NP,
  parameter int unsigned ADDR_W  = LSP_ADDR_W,
  parameter int unsigned CADDR_W = LSP_CADDR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               done,
  input  logic [ADDR_W-1:0]  lspEleAddr,
  input  logic [ADDR_W-1:0]  freqPrevAddr,
  input  logic [ADDR_W-1:0]  lspAddr,
  input  logic [CADDR_W-1:0] fgSumAddr,
  input  logic [CADDR_W-1:0] fgAddr,
  output logic [ADDR_W-1:0]  readAddr,
  input  logic [31:0]        readIn,
  output logic [ADDR_W-1:0]  writeAddr,
  output logic [31:0]        writeOut,
  output logic               writeEn,
  output logic [CADDR_W-1:0] constantMemAddr,
  input  logic [31:0]        constantMemIn,
  output logic [15:0]        L_mult_a,
  output logic [15:0]        L_mult_b,
  input  logic [31:0]        L_mult_in,
  output logic [15:0]        L_mac_a,
  output logic [15:0]        L_mac_b,
  output logic [31:0]        L_mac_c,
  input  logic [31:0]        L_mac_in
`ifdef LSP_PREV_COMPOSE_OVF_EN
  ,
  input  logic               L_mult_overflow,
  input  logic               L_mac_overflow,
  output logic               ovfFlag
`endif
);

  lsp_state_t state_q, state_d;

  logic clr_j, inc_j, clr_k, inc_k;
  logic last_j, last_k;
  logic [ADDR_W-1:0]  ele_addr, fp_addr, wr_addr;
  logic [CADDR_W-1:0] fg_sum_addr, fg_addr;

  logic [31:0] acc;
  logic        mult_pend;
  logic        mac_pend;

  // Only the low halves of memory words are operands
  logic unused_hi;
  assign unused_hi = ^{readIn[31:16], constantMemIn[31:16]};

  lsp_prev_compose_agen #(
    .M       (M),
    .MA_NP   (MA_NP),
    .ADDR_W  (ADDR_W),
    .CADDR_W (CADDR_W)
  ) u_agen (
    .clk            (clk),
    .reset          (reset),
    .clr_j          (clr_j),
    .inc_j          (inc_j),
    .clr_k          (clr_k),
    .inc_k          (inc_k),
    .lsp_ele_base   (lspEleAddr),
    .freq_prev_base (freqPrevAddr),
    .lsp_base       (lspAddr),
    .fg_sum_base    (fgSumAddr),
    .fg_base        (fgAddr),
    .last_j         (last_j),
    .last_k         (last_k),
    .ele_addr       (ele_addr),
    .fp_addr        (fp_addr),
    .wr_addr        (wr_addr),
    .fg_sum_addr    (fg_sum_addr),
    .fg_addr        (fg_addr)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and counter control
  always_comb begin
    state_d = state_q;
    clr_j   = 1'b0;
    inc_j   = 1'b0;
    clr_k   = 1'b0;
    inc_k   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          clr_j   = 1'b1;
          state_d = ST_RD_INIT;
        end
      end
      ST_RD_INIT: state_d = ST_MULT;
      ST_MULT: begin
        clr_k   = 1'b1;
        state_d = ST_RD_MAC;
      end
      ST_RD_MAC: state_d = ST_MAC;
      ST_MAC: begin
        if (last_k) begin
          state_d = ST_WRITE;
        end else begin
          inc_k   = 1'b1;
          state_d = ST_RD_MAC;
        end
      end
      ST_WRITE: begin
        if (last_j) begin
          state_d = ST_DONE;
        end else begin
          inc_j   = 1'b1;
          state_d = ST_RD_INIT;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered memory, operator and strobe outputs plus the accumulator
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      readAddr        <= '0;
      constantMemAddr <= '0;
      writeAddr       <= '0;
      writeOut        <= '0;
      writeEn         <= 1'b0;
      done            <= 1'b0;
      L_mult_a        <= '0;
      L_mult_b        <= '0;
      L_mac_a         <= '0;
      L_mac_b         <= '0;
      L_mac_c         <= '0;
      acc             <= '0;
      mult_pend       <= 1'b0;
      mac_pend        <= 1'b0;
    end else begin
      if (state_d == ST_RD_INIT) begin
        readAddr        <= ele_addr;
        constantMemAddr <= fg_sum_addr;
      end else if (state_d == ST_RD_MAC) begin
        readAddr        <= fp_addr;
        constantMemAddr <= fg_addr;
      end

      if (state_q == ST_MULT) begin
        L_mult_a <= readIn[15:0];
        L_mult_b <= constantMemIn[15:0];
      end
      if (state_q == ST_MAC) begin
        L_mac_a <= readIn[15:0];
        L_mac_b <= constantMemIn[15:0];
        L_mac_c <= acc;
      end
      mult_pend <= (state_q == ST_MULT);
      mac_pend  <= (state_q == ST_MAC);

      if (mult_pend) begin
        acc <= L_mult_in;
      end else if (mac_pend) begin
        acc <= L_mac_in;
      end

      // In WRITE the last L_mac result is still on L_mac_in
      writeEn <= (state_q == ST_WRITE);
      if (state_q == ST_WRITE) begin
        writeAddr <= wr_addr;
        writeOut  <= sext16(L_mac_in[31:16]);
      end

      done <= (state_d == ST_DONE);
    end
  end

`ifdef LSP_PREV_COMPOSE_OVF_EN
  // Sticky overflow, observed while the operator holds that step's operands
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovfFlag <= 1'b0;
    end else if (state_q == ST_IDLE && start) begin
      ovfFlag <= 1'b0;
    end else if ((mult_pend && L_mult_overflow) || (mac_pend && L_mac_overflow)) begin
      ovfFlag <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_lsp_prev_compose_ctrl.sv
// Self-checking bench for lsp_prev_compose_ctrl: behavioural scratch/constant
// memories, saturating L_mult/L_mac operators and a formula-level reference.
module tb_lsp_prev_compose_ctrl;

  localparam int M  = 10;
  localparam int NP = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        done;
  logic [10:0] le_b = '0, fp_b = '0, lsp_b = '0;
  logic [11:0] fs_b = '0, fg_b = '0;
  logic [10:0] readAddr, writeAddr;
  logic [31:0] readIn = '0, writeOut, constantMemIn = '0;
  logic        writeEn;
  logic [11:0] constantMemAddr;
  logic [15:0] L_mult_a, L_mult_b, L_mac_a, L_mac_b;
  logic [31:0] L_mult_in, L_mac_c, L_mac_in;
`ifdef LSP_PREV_COMPOSE_OVF_EN
  logic L_mult_overflow, L_mac_overflow, ovfFlag;
`endif

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [31:0] smem [2048];
  logic [31:0] cmem [4096];
  logic [31:0] ele [M];
  logic [31:0] fgs [M];
  logic [31:0] fp  [NP][M];
  logic [31:0] fgm [NP][M];

  int          wr_cyc_q [$];
  logic [10:0] wr_addr_q [$];
  logic [31:0] wr_data_q [$];
  int          done_q [$];

  lsp_prev_compose_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .done            (done),
    .lspEleAddr      (le_b),
    .freqPrevAddr    (fp_b),
    .lspAddr         (lsp_b),
    .fgSumAddr       (fs_b),
    .fgAddr          (fg_b),
    .readAddr        (readAddr),
    .readIn          (readIn),
    .writeAddr       (writeAddr),
    .writeOut        (writeOut),
    .writeEn         (writeEn),
    .constantMemAddr (constantMemAddr),
    .constantMemIn   (constantMemIn),
    .L_mult_a        (L_mult_a),
    .L_mult_b        (L_mult_b),
    .L_mult_in       (L_mult_in),
    .L_mac_a         (L_mac_a),
    .L_mac_b         (L_mac_b),
    .L_mac_c         (L_mac_c),
    .L_mac_in        (L_mac_in)
`ifdef LSP_PREV_COMPOSE_OVF_EN
    ,
    .L_mult_overflow (L_mult_overflow),
    .L_mac_overflow  (L_mac_overflow),
    .ovfFlag         (ovfFlag)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] sat32(input longint v);
    if (v > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (v < -64'sd2147483648) return 32'h8000_0000;
    return v[31:0];
  endfunction

  function automatic logic [31:0] l_mult(input logic [15:0] a, input logic [15:0] b);
    longint p;
    p = 2 * longint'($signed(a)) * longint'($signed(b));
    return sat32(p);
  endfunction

  function automatic logic [31:0] l_add(input logic [31:0] a, input logic [31:0] b);
    return sat32(longint'($signed(a)) + longint'($signed(b)));
  endfunction

  // External saturating operators
  always_comb begin
    L_mult_in = l_mult(L_mult_a, L_mult_b);
    L_mac_in  = l_add(L_mac_c, l_mult(L_mac_a, L_mac_b));
  end

`ifdef LSP_PREV_COMPOSE_OVF_EN
  always_comb begin
    L_mult_overflow = (L_mult_a == 16'h8000) && (L_mult_b == 16'h8000);
    L_mac_overflow  = ((longint'($signed(L_mac_c)) +
                        2 * longint'($signed(L_mac_a)) * longint'($signed(L_mac_b))) > 64'sd2147483647) ||
                      ((longint'($signed(L_mac_c)) +
                        2 * longint'($signed(L_mac_a)) * longint'($signed(L_mac_b))) < -64'sd2147483648) ||
                      ((L_mac_a == 16'h8000) && (L_mac_b == 16'h8000));
  end
`endif

  // Memories with one-cycle read latency
  always @(posedge clk) begin
    cyc <= cyc + 1;
    readIn <= smem[readAddr];
    constantMemIn <= cmem[constantMemAddr];
    if (writeEn) smem[writeAddr] <= writeOut;
  end

  // Write / done monitor
  always @(negedge clk) begin
    if (writeEn) begin
      wr_cyc_q.push_back(cyc);
      wr_addr_q.push_back(writeAddr);
      wr_data_q.push_back(writeOut);
    end
    if (done) done_q.push_back(cyc);
  end

  // Reference: the compose formula evaluated directly on the source arrays
  function automatic logic [31:0] ref_lsp(input int j);
    logic [31:0] a;
    a = l_mult(ele[j][15:0], fgs[j][15:0]);
    for (int k = 0; k < NP; k++) a = l_add(a, l_mult(fp[k][j][15:0], fgm[k][j][15:0]));
    return {{16{a[31]}}, a[31:16]};
  endfunction

  task automatic load_mem();
    for (int j = 0; j < M; j++) begin
      smem[(int'(le_b) + j) % 2048] = ele[j];
      cmem[(int'(fs_b) + j) % 4096] = fgs[j];
      for (int k = 0; k < NP; k++) begin
        smem[(int'(fp_b) + k * M + j) % 2048] = fp[k][j];
        cmem[(int'(fg_b) + k * M + j) % 4096] = fgm[k][j];
      end
    end
  endtask

  task automatic fill_random();
    for (int j = 0; j < M; j++) begin
      ele[j] = $urandom;
      fgs[j] = $urandom;
      for (int k = 0; k < NP; k++) begin
        fp[k][j]  = $urandom;
        fgm[k][j] = $urandom;
      end
    end
  endtask

  // Start a job, run 130 cycles; cycle 1 is the one after the start-sampling edge
  task automatic run_job(input int restart_at, input int reset_at, output int s);
    wr_cyc_q.delete();
    wr_addr_q.delete();
    wr_data_q.delete();
    done_q.delete();
    load_mem();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 s = cyc;
    for (int n = 1; n <= 130; n++) begin
      @(negedge clk);
      start = (n == restart_at);
      reset = (n != reset_at);
    end
    start = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({done, writeEn, readAddr, writeAddr, writeOut, constantMemAddr,
         L_mult_a, L_mult_b, L_mac_a, L_mac_b, L_mac_c} !== '0) begin
      fails++;
      $display("FAIL reset_outputs got done=%b we=%b ra=%h wa=%h wd=%h ca=%h want all 0",
               done, writeEn, readAddr, writeAddr, writeOut, constantMemAddr);
    end
    reset = 1'b1;
    repeat (20) @(negedge clk);
    tests++;
    if ({done, writeEn, readAddr, writeAddr, writeOut, constantMemAddr,
         L_mult_a, L_mult_b, L_mac_a, L_mac_b, L_mac_c} !== '0) begin
      fails++;
      $display("FAIL idle_outputs got done=%b we=%b ra=%h ca=%h want all 0",
               done, writeEn, readAddr, constantMemAddr);
    end
    tests++;
    if (wr_data_q.size() != 0 || done_q.size() != 0) begin
      fails++;
      $display("FAIL idle_activity got writes=%0d dones=%0d want 0 0", wr_data_q.size(), done_q.size());
    end
`ifdef LSP_PREV_COMPOSE_OVF_EN
    tests++;
    if (ovfFlag !== 1'b0) begin
      fails++;
      $display("FAIL reset_ovf got %b want 0", ovfFlag);
    end
`endif
  endtask

  task automatic test_patterns();
    logic [15:0] pe [4];
    logic [15:0] pg [4];
    logic [15:0] pf [4];
    logic [15:0] pk [4];
    logic [31:0] pw [4];
    int s, dc;
    logic [10:0] ea;
    pe = '{16'h1000, 16'h0000, 16'h8000, 16'h8000};
    pg = '{16'h4000, 16'h4000, 16'h4000, 16'h8000};
    pf = '{16'h0000, 16'h2000, 16'h0000, 16'h0000};
    pk = '{16'h0000, 16'h1000, 16'h0000, 16'h0000};
    pw = '{32'h0000_0800, 32'h0000_1000, 32'hFFFF_C000, 32'h0000_7FFF};
    le_b = 11'h010; fp_b = 11'h100; lsp_b = 11'h300; fs_b = 12'h020; fg_b = 12'h200;
    for (int p = 0; p < 4; p++) begin
      for (int j = 0; j < M; j++) begin
        ele[j] = {16'($urandom), pe[p]};
        fgs[j] = {16'($urandom), pg[p]};
        for (int k = 0; k < NP; k++) begin
          fp[k][j]  = {16'($urandom), pf[p]};
          fgm[k][j] = {16'($urandom), pk[p]};
        end
      end
      run_job(0, 0, s);
      dc = (done_q.size() > 0) ? done_q[0] - s + 1 : -1;
      tests++;
      if (wr_data_q.size() != M) begin
        fails++;
        $display("FAIL pat%0d_write_count got %0d want %0d", p, wr_data_q.size(), M);
      end
      tests++;
      if (done_q.size() != 1 || dc != 111) begin
        fails++;
        $display("FAIL pat%0d_done got count=%0d cycle=%0d want 1 at 111", p, done_q.size(), dc);
      end
      for (int j = 0; j < M && j < wr_data_q.size(); j++) begin
        ea = lsp_b + 11'(j);
        tests++;
        if (wr_addr_q[j] !== ea || wr_data_q[j] !== pw[p]) begin
          fails++;
          $display("FAIL pat%0d_write[%0d] got %h@%h want %h@%h", p, j, wr_data_q[j], wr_addr_q[j], pw[p], ea);
        end
      end
`ifdef LSP_PREV_COMPOSE_OVF_EN
      tests++;
      if (ovfFlag !== (p == 3)) begin
        fails++;
        $display("FAIL pat%0d_ovf got %b want %b", p, ovfFlag, (p == 3));
      end
`endif
    end
  endtask

  task automatic test_random();
    int s, dc;
    logic [10:0] ea;
    for (int it = 0; it < 3; it++) begin
      fill_random();
      le_b  = 11'($urandom_range(0, 16'h0F0));
      fp_b  = 11'($urandom_range(16'h200, 16'h2D0));
      lsp_b = 11'($urandom_range(16'h400, 16'h4F0));
      fs_b  = 12'($urandom_range(0, 16'h7F0));
      fg_b  = 12'($urandom_range(16'h800, 16'hF00));
      repeat ($urandom_range(0, 5)) @(negedge clk);
      run_job(0, 0, s);
      dc = (done_q.size() > 0) ? done_q[0] - s + 1 : -1;
      tests++;
      if (wr_data_q.size() != M || done_q.size() != 1 || dc != 111) begin
        fails++;
        $display("FAIL rand%0d_shape got writes=%0d dones=%0d cycle=%0d want %0d 1 111",
                 it, wr_data_q.size(), done_q.size(), dc, M);
      end
      for (int j = 0; j < M && j < wr_data_q.size(); j++) begin
        ea = lsp_b + 11'(j);
        tests++;
        if (wr_addr_q[j] !== ea || wr_data_q[j] !== ref_lsp(j)) begin
          fails++;
          $display("FAIL rand%0d_write[%0d] got %h@%h want %h@%h", it, j, wr_data_q[j], wr_addr_q[j], ref_lsp(j), ea);
        end
      end
    end
  endtask

  task automatic test_restart_ignored();
    int s, dc;
    fill_random();
    le_b = 11'h020; fp_b = 11'h140; lsp_b = 11'h500; fs_b = 12'h040; fg_b = 12'h300;
    run_job(40, 0, s);
    dc = (done_q.size() > 0) ? done_q[0] - s + 1 : -1;
    tests++;
    if (wr_data_q.size() != M || done_q.size() != 1 || dc != 111) begin
      fails++;
      $display("FAIL restart_shape got writes=%0d dones=%0d cycle=%0d want %0d 1 111",
               wr_data_q.size(), done_q.size(), dc, M);
    end
    for (int j = 0; j < M && j < wr_data_q.size(); j++) begin
      tests++;
      if (wr_data_q[j] !== ref_lsp(j)) begin
        fails++;
        $display("FAIL restart_write[%0d] got %h want %h", j, wr_data_q[j], ref_lsp(j));
      end
    end
  endtask

  task automatic test_reset_abort();
    int s, bad;
    fill_random();
    le_b = 11'h030; fp_b = 11'h180; lsp_b = 11'h600; fs_b = 12'h060; fg_b = 12'h400;
    run_job(0, 50, s);
    bad = 0;
    foreach (wr_cyc_q[i]) if (wr_cyc_q[i] - s + 1 >= 50) bad++;
    tests++;
    if (bad != 0 || done_q.size() != 0) begin
      fails++;
      $display("FAIL abort_quiet got late_writes=%0d dones=%0d want 0 0", bad, done_q.size());
    end
    // a fresh job after the abort must run normally
    fill_random();
    run_job(0, 0, s);
    tests++;
    if (wr_data_q.size() != M || done_q.size() != 1) begin
      fails++;
      $display("FAIL abort_rerun got writes=%0d dones=%0d want %0d 1", wr_data_q.size(), done_q.size(), M);
    end
    for (int j = 0; j < M && j < wr_data_q.size(); j++) begin
      tests++;
      if (wr_data_q[j] !== ref_lsp(j)) begin
        fails++;
        $display("FAIL abort_rerun_write[%0d] got %h want %h", j, wr_data_q[j], ref_lsp(j));
      end
    end
  endtask

  task automatic test_wrap_inplace();
    int s;
    logic [10:0] ea;
    for (int mode = 0; mode < 2; mode++) begin
      fill_random();
      le_b = 11'h100; fp_b = 11'h200; fs_b = 12'hFFA; fg_b = 12'h500;
      lsp_b = (mode == 0) ? 11'h7FC : le_b;
      run_job(0, 0, s);
      tests++;
      if (wr_data_q.size() != M) begin
        fails++;
        $display("FAIL wrap%0d_write_count got %0d want %0d", mode, wr_data_q.size(), M);
      end
      for (int j = 0; j < M && j < wr_data_q.size(); j++) begin
        ea = 11'((int'(lsp_b) + j) % 2048);
        tests++;
        if (wr_addr_q[j] !== ea || wr_data_q[j] !== ref_lsp(j)) begin
          fails++;
          $display("FAIL wrap%0d_write[%0d] got %h@%h want %h@%h", mode, j, wr_data_q[j], wr_addr_q[j], ref_lsp(j), ea);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_random();
    test_restart_ignored();
    test_reset_abort();
    test_wrap_inplace();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    fails++;
    $display("FAIL watchdog got timeout want completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

endmodule
